// File: rtl/bitstream_gen_if.sv
// Handshake bundle between the stochastic bitstream generator and its
// producer (value/start) and consumer (ready) sides.
interface bitstream_gen_if;
    logic [7:0] value;
    logic       start;
    logic       ready;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       done;

    modport master (
        output value, start, ready,
        input  x, x_valid, busy, done
    );

    modport slave (
        input  value, start, ready,
        output x, x_valid, busy, done
    );
endinterface

// File: rtl/bitstream_gen.sv
// Stochastic bitstream generator: compares a maximal-length 8-bit LFSR against
// a latched probability numerator, emitting exactly value ones in 255 bits.
module bitstream_gen #(
    parameter logic [7:0]  SEED   = 8'h01,
    parameter int unsigned LENGTH = 255
) (
    input logic            clk,
    input logic            rst,
    bitstream_gen_if.slave bus
);

    localparam logic [7:0] LastCnt = 8'(LENGTH);

    typedef enum logic {StIdle, StRun} state_t;

    state_t     state;
    logic [7:0] lfsr;
    logic [7:0] value_reg;
    logic [7:0] cnt;
    logic       x_reg;
    logic       x_valid_reg;
    logic       done_reg;
    logic [7:0] lfsr_next;

    // x^8+x^6+x^5+x^4+1, Fibonacci form; never reaches zero from a nonzero seed.
    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            lfsr        <= SEED;
            value_reg   <= 8'd0;
            cnt         <= 8'd0;
            x_reg       <= 1'b0;
            x_valid_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        value_reg <= bus.value;
                        lfsr      <= SEED;
                        cnt       <= 8'd0;
                        state     <= StRun;
                    end
                end
                StRun: begin
                    if (x_valid_reg && bus.ready && (cnt == LastCnt)) begin
                        x_reg       <= 1'b0;
                        x_valid_reg <= 1'b0;
                        done_reg    <= 1'b1;
                        state       <= StIdle;
                    end else if ((!x_valid_reg || bus.ready) && (cnt < LastCnt)) begin
                        // Stalled bits (valid && !ready) fall through and hold everything.
                        x_reg       <= (lfsr <= value_reg);
                        x_valid_reg <= 1'b1;
                        lfsr        <= lfsr_next;
                        cnt         <= cnt + 8'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.x       = x_reg;
    assign bus.x_valid = x_valid_reg;
    assign bus.busy    = (state == StRun);
    assign bus.done    = done_reg;

    seed_nonzero_a: assert property (@(posedge clk) SEED != 8'h00)
        else $error("bitstream_gen: SEED must be nonzero");

    length_fixed_a: assert property (@(posedge clk) LENGTH == 255)
        else $error("bitstream_gen: LENGTH must be 255");

endmodule

// File: tb/tb_bitstream_gen.sv
// Scoreboard bench for bitstream_gen: driver queues expected bits per stream,
// a negedge monitor pops and compares on every handshake.
module tb_bitstream_gen;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;

    bitstream_gen_if bus ();

    bitstream_gen #(.SEED(8'h01), .LENGTH(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    logic got[$];
    logic ref128[$];
    int   first_valid_cyc = -1;
    int   done_cyc = -1;
    int   busy_cnt = 0;
    bit   done_seen = 0;
    bit   exp_done = 0;
    bit   hold_pending = 0;
    logic hold_x = 1'b0;
    bit   rand_ready = 0;
    int   e0 = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Ready driver: constant 1 or ~50% random, always changed away from both edges.
    initial begin
        forever begin
            bus.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #2;
        end
    end

    // Monitor: handshakes, stall stability, idle-zero x, done timing.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pending = 0;
                exp_done     = 0;
            end else begin
                if (!bus.x_valid) check("x_idle_zero", int'(bus.x), 0);
                if (hold_pending)
                    check("stall_hold", int'({bus.x_valid, bus.x}), int'({1'b1, hold_x}));
                hold_pending = bus.x_valid && !bus.ready;
                hold_x       = bus.x;
                if (bus.done || exp_done) check("done_pulse", int'(bus.done), int'(exp_done));
                if (bus.done) begin
                    done_seen = 1;
                    done_cyc  = cyc;
                end
                exp_done = 0;
                if (bus.busy) busy_cnt++;
                if (bus.x_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (bus.x_valid && bus.ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_bit", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("stream_bit", int'(bus.x), int'(e.b));
                        got.push_back(bus.x);
                        if (e.last) exp_done = 1;
                    end
                end
            end
        end
    end

    function automatic int ones(input logic q[$]);
        int n = 0;
        foreach (q[i]) n += int'(q[i]);
        return n;
    endfunction

    task automatic start_stream(input logic [7:0] v);
        logic [7:0] l;
        got.delete();
        first_valid_cyc = -1;
        done_seen       = 0;
        busy_cnt        = 0;
        tick();
        bus.value = v;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        e0 = cyc;
        check("busy_after_start", int'(bus.busy), 1);
        l = 8'h01;
        for (int k = 0; k < 255; k++) begin
            exp_t e;
            e.b    = (l <= v);
            e.last = (k == 254);
            exp_q.push_back(e);
            l = {l[6:0], ^(l & 8'hB8)};
        end
    endtask

    task automatic finish_stream(input logic [7:0] v, input bit chk_lat);
        int n = 0;
        while (!done_seen && n < 3000) begin
            tick();
            n++;
        end
        check("done_timeout", int'(done_seen), 1);
        check("bit_count", got.size(), 255);
        check("ones_count", ones(got), int'(v));
        check("queue_empty", exp_q.size(), 0);
        check("busy_after_done", int'(bus.busy), 0);
        if (chk_lat) begin
            check("first_valid_lat", first_valid_cyc - e0, 1);
            check("done_lat", done_cyc - e0, 256);
            check("busy_cycles", busy_cnt, 256);
        end
    endtask

    task automatic wait_bits(input int nbits);
        int n = 0;
        while (got.size() < nbits && n < 3000) begin
            tick();
            n++;
        end
        check("wait_bits_timeout", int'(got.size() >= nbits), 1);
    endtask

    task automatic compare_ref(input string name);
        int mism = 0;
        if (got.size() != ref128.size()) mism = 1000;
        else foreach (got[i]) if (got[i] !== ref128[i]) mism++;
        check(name, mism, 0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.value = 8'd0;
        bus.start = 1'b0;
        repeat (3) tick();
        check("rst_x", int'(bus.x), 0);
        check("rst_x_valid", int'(bus.x_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        rst = 1'b0;

        start_stream(8'd0);
        finish_stream(8'd0, 1);

        start_stream(8'd255);
        finish_stream(8'd255, 1);

        start_stream(8'd128);
        finish_stream(8'd128, 1);
        check("v128_bit0", int'(got[0]), 1);
        check("v128_bit1", int'(got[1]), 1);
        ref128 = got;

        rand_ready = 1;
        start_stream(8'd128);
        finish_stream(8'd128, 0);
        compare_ref("rand_ready_seq");
        rand_ready = 0;

        // A start pulse mid-stream must not restart or relatch value.
        start_stream(8'd1);
        wait_bits(50);
        bus.value = 8'hFF;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        finish_stream(8'd1, 0);
        check("v1_bit0", int'(got[0]), 1);

        // Reset mid-stream abandons it without a done pulse.
        start_stream(8'd128);
        wait_bits(100);
        rst = 1'b1;
        tick();
        check("midrst_x", int'(bus.x), 0);
        check("midrst_x_valid", int'(bus.x_valid), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        exp_q.delete();
        rst = 1'b0;
        start_stream(8'd128);
        finish_stream(8'd128, 1);
        compare_ref("post_reset_seq");

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
